// File: rtl/cache_lru_profiler_pkg.sv
// Shared definitions for the LRU stack profiler.
//   clog2_f   : constant log2 (ceiling) used to size derived fields
//   VALID_BIT : position of the valid flag inside the 2-bit flag field
//   DIRTY_BIT : position of the dirty flag inside the 2-bit flag field
//   state_t   : profiler FSM states
// A line is stored as {flags[1:0], tag}, so a flag lives at bit TAG_W+<flag>.
package cache_sim_pkg;

    localparam int FLAG_W    = 2;
    localparam int VALID_BIT = 1;
    localparam int DIRTY_BIT = 0;

    typedef enum logic [2:0] {
        FLUSH,
        IDLE,
        LOOKUP,
        SHIFT,
        RESP
    } state_t;

    function automatic int clog2_f(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/cache_lru_profiler_if.sv
// Request/response bus between the trace-fetch FSM (master) and the
// profiler (slave).
//   req_valid/req_ready/req_addr/req_store : one trace entry per handshake
//   resp_valid/resp_hit/resp_pos/resp_evict_dirty : one-cycle result pulse
interface cache_lru_profiler_if #(
    parameter int ADDR_W = 32,
    parameter int POS_W  = 5
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              req_store;
    logic              resp_valid;
    logic              resp_hit;
    logic [POS_W-1:0]  resp_pos;
    logic              resp_evict_dirty;

    modport master (
        output req_valid, req_addr, req_store,
        input  req_ready, resp_valid, resp_hit, resp_pos, resp_evict_dirty
    );

    modport slave (
        input  req_valid, req_addr, req_store,
        output req_ready, resp_valid, resp_hit, resp_pos, resp_evict_dirty
    );
endinterface

// File: rtl/cache_lru_profiler_sat_counter.sv
// Saturating statistics counter.
//   clk   : clock
//   inc   : add one unless already all-ones
//   clr   : synchronous clear, wins over inc
//   count : current value
module sat_counter #(
    parameter int CNT_W = 20
) (
    input  logic             clk,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr)
            count_d = '0;
        else if (inc && (count_q != '1))
            count_d = count_q + CNT_W'(1);
    end

    always_ff @(posedge clk) count_q <= count_d;

    assign count = count_q;
endmodule

// File: rtl/cache_lru_profiler.sv
// Set-associative true-LRU cache model with a per-stack-depth hit histogram.
//   clk, reset (sync, active-high, starts a flush), stats_clr (counters only)
//   bus               : request/response handshake (slave side)
//   busy              : high in every state except IDLE
//   hit_hist          : packed, slice i = hits found at stack position i
//   access_count, miss_count, dirty_evict_count : saturating statistics
//
// state  | meaning
// FLUSH  | clear one set per cycle, set 0 first
// IDLE   | accept a request
// LOOKUP | parallel tag compare, update statistics
// SHIFT  | move recency stack down (p cycles on hit, 1 on miss)
// RESP   | one-cycle response pulse
module cache_lru_profiler
    import cache_sim_pkg::*;
#(
    parameter int WAYS        = 16,
    parameter int SETS        = 64,
    parameter int BLOCK_BYTES = 16,
    parameter int ADDR_W      = 32,
    parameter int CNT_W       = 20
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stats_clr,
    cache_lru_profiler_if.slave   bus,
    output logic                  busy,
    output logic [WAYS*CNT_W-1:0] hit_hist,
    output logic [CNT_W-1:0]      access_count,
    output logic [CNT_W-1:0]      miss_count,
    output logic [CNT_W-1:0]      dirty_evict_count
);
    localparam int OFF_W  = clog2_f(BLOCK_BYTES);
    localparam int IDX_W  = clog2_f(SETS);
    localparam int WAY_W  = clog2_f(WAYS);
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int LINE_W = TAG_W + FLAG_W;
    localparam int POS_W  = WAY_W + 1;

    typedef logic [LINE_W-1:0] line_t;

    line_t mem_q [SETS][WAYS];
    line_t cur_set [WAYS];
    line_t wr_set  [WAYS];
    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  flush_idx_q, flush_idx_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic              store_q, store_d;
    logic              hit_q, hit_d;
    logic [POS_W-1:0]  pos_q, pos_d;
    logic [WAY_W-1:0]  k_q, k_d;
    line_t             line_q, line_d;
    logic              evict_q, evict_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              rv_q, rv_d;
    logic              rhit_q, rhit_d;
    logic [POS_W-1:0]  rpos_q, rpos_d;
    logic              rev_q, rev_d;

    logic              match_any;
    logic [WAY_W-1:0]  match_pos;
    logic              acc_inc, miss_inc, dev_inc, cnt_clr;
    logic [WAYS-1:0]   hist_inc;
    logic              unused_offset;

    assign unused_offset = ^bus.req_addr[OFF_W-1:0];

    always_comb begin
        for (int w = 0; w < WAYS; w++) cur_set[w] = mem_q[idx_q][w];
    end

    // Descending scan so the lowest matching position is the one kept.
    always_comb begin
        match_any = 1'b0;
        match_pos = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (cur_set[w][TAG_W+VALID_BIT] && (cur_set[w][TAG_W-1:0] == tag_q)) begin
                match_any = 1'b1;
                match_pos = WAY_W'(w);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        flush_idx_d = flush_idx_q;
        idx_d       = idx_q;
        tag_d       = tag_q;
        store_d     = store_q;
        hit_d       = hit_q;
        pos_d       = pos_q;
        k_d         = k_q;
        line_d      = line_q;
        evict_d     = evict_q;
        rhit_d      = rhit_q;
        rpos_d      = rpos_q;
        rev_d       = rev_q;
        wr_en       = 1'b0;
        wr_idx      = idx_q;
        for (int w = 0; w < WAYS; w++) wr_set[w] = cur_set[w];
        acc_inc     = 1'b0;
        miss_inc    = 1'b0;
        dev_inc     = 1'b0;
        hist_inc    = '0;

        case (state_q)
            FLUSH: begin
                wr_en  = 1'b1;
                wr_idx = flush_idx_q;
                for (int w = 0; w < WAYS; w++) wr_set[w] = '0;
                flush_idx_d = flush_idx_q + IDX_W'(1);
                if (flush_idx_q == IDX_W'(SETS - 1)) state_d = IDLE;
            end
            IDLE: begin
                if (bus.req_valid) begin
                    idx_d   = bus.req_addr[OFF_W +: IDX_W];
                    tag_d   = bus.req_addr[ADDR_W-1 -: TAG_W];
                    store_d = bus.req_store;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                acc_inc = 1'b1;
                if (match_any) begin
                    hit_d   = 1'b1;
                    pos_d   = {1'b0, match_pos};
                    evict_d = 1'b0;
                    line_d  = cur_set[match_pos];
                    if (store_q) line_d[TAG_W+DIRTY_BIT] = 1'b1;
                    hist_inc[match_pos] = 1'b1;
                    if (match_pos == '0) begin
                        wr_en     = 1'b1;
                        wr_set[0] = line_d;
                        state_d   = RESP;
                    end else begin
                        k_d     = match_pos;
                        state_d = SHIFT;
                    end
                end else begin
                    hit_d    = 1'b0;
                    pos_d    = POS_W'(WAYS);
                    miss_inc = 1'b1;
                    evict_d  = cur_set[WAYS-1][TAG_W+VALID_BIT] && cur_set[WAYS-1][TAG_W+DIRTY_BIT];
                    dev_inc  = evict_d;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                wr_en = 1'b1;
                if (hit_q) begin
                    wr_set[k_q] = cur_set[k_q - WAY_W'(1)];
                    k_d = k_q - WAY_W'(1);
                    if (k_q == WAY_W'(1)) begin
                        wr_set[0] = line_q;
                        state_d   = RESP;
                    end
                end else begin
                    for (int w = 1; w < WAYS; w++) wr_set[w] = cur_set[w-1];
                    wr_set[0] = {1'b1, store_q, tag_q};
                    state_d   = RESP;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = FLUSH;
        endcase

        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
        rv_d    = (state_d == RESP);
        if (state_d == RESP) begin
            rhit_d = hit_d;
            rpos_d = pos_d;
            rev_d  = evict_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= FLUSH;
            flush_idx_q <= '0;
            idx_q       <= '0;
            tag_q       <= '0;
            store_q     <= 1'b0;
            hit_q       <= 1'b0;
            pos_q       <= '0;
            k_q         <= '0;
            line_q      <= '0;
            evict_q     <= 1'b0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b1;
            rv_q        <= 1'b0;
            rhit_q      <= 1'b0;
            rpos_q      <= '0;
            rev_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_idx_q <= flush_idx_d;
            idx_q       <= idx_d;
            tag_q       <= tag_d;
            store_q     <= store_d;
            hit_q       <= hit_d;
            pos_q       <= pos_d;
            k_q         <= k_d;
            line_q      <= line_d;
            evict_q     <= evict_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            rv_q        <= rv_d;
            rhit_q      <= rhit_d;
            rpos_q      <= rpos_d;
            rev_q       <= rev_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !reset) mem_q[wr_idx] <= wr_set;
    end

    assign cnt_clr = reset | stats_clr;

    sat_counter #(.CNT_W(CNT_W)) u_access (.clk(clk), .inc(acc_inc),  .clr(cnt_clr), .count(access_count));
    sat_counter #(.CNT_W(CNT_W)) u_miss   (.clk(clk), .inc(miss_inc), .clr(cnt_clr), .count(miss_count));
    sat_counter #(.CNT_W(CNT_W)) u_devict (.clk(clk), .inc(dev_inc),  .clr(cnt_clr), .count(dirty_evict_count));

    for (genvar i = 0; i < WAYS; i++) begin : g_hist
        sat_counter #(.CNT_W(CNT_W)) u_hist (
            .clk(clk), .inc(hist_inc[i]), .clr(cnt_clr), .count(hit_hist[i*CNT_W +: CNT_W])
        );
    end

    assign bus.req_ready        = ready_q;
    assign bus.resp_valid       = rv_q;
    assign bus.resp_hit         = rhit_q;
    assign bus.resp_pos         = rpos_q;
    assign bus.resp_evict_dirty = rev_q;
    assign busy                 = busy_q;
endmodule

// File: tb/tb_cache_lru_profiler.sv
module tb_cache_lru_profiler;
    localparam int CNT_W = 4;
    localparam int WAYS  = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic stats_clr = 1'b0;
    logic busy;
    logic [WAYS*CNT_W-1:0] hit_hist;
    logic [CNT_W-1:0] access_count, miss_count, dirty_evict_count;

    cache_lru_profiler_if #(.ADDR_W(32), .POS_W(5)) bus ();

    cache_lru_profiler #(
        .WAYS(WAYS), .SETS(64), .BLOCK_BYTES(16), .ADDR_W(32), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .stats_clr(stats_clr), .bus(bus), .busy(busy),
        .hit_hist(hit_hist), .access_count(access_count), .miss_count(miss_count),
        .dirty_evict_count(dirty_evict_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic       hit;
        logic [4:0] pos;
        logic       ev;
        int         t;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int vec = 0;
    int errs = 0;

    // Response monitor: pops the scoreboard whenever a response is presented.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.resp_valid === 1'b1) begin
                vec++;
                if (sb.size() == 0) begin
                    errs++;
                    $display("FAIL unexpected_resp: got resp_valid=1 at cycle %0d, expected none", cyc);
                end else begin
                    e = sb.pop_front();
                    if (bus.resp_hit !== e.hit || bus.resp_pos !== e.pos ||
                        bus.resp_evict_dirty !== e.ev || (cyc - e.t) != e.lat) begin
                        errs++;
                        $display("FAIL resp: got hit=%0d pos=%0d ev=%0d lat=%0d, expected hit=%0d pos=%0d ev=%0d lat=%0d",
                                 bus.resp_hit, bus.resp_pos, bus.resp_evict_dirty, cyc - e.t,
                                 e.hit, e.pos, e.ev, e.lat);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        vec++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic hs(input logic [31:0] a, input logic st, output int t);
        int n;
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (bus.req_ready !== 1'b1) begin
            vec++;
            errs++;
            $display("FAIL ready_timeout: got req_ready=%0d expected 1", bus.req_ready);
        end
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        bus.req_store = st;
        t = cyc;
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            vec++;
            errs++;
            $display("FAIL resp_timeout: got %0d pending responses expected 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic access(input logic [31:0] a, input logic st, input logic eh,
                          input int ep, input logic ee);
        exp_t e;
        int t;
        hs(a, st, t);
        e.hit = eh;
        e.pos = 5'(ep);
        e.ev  = ee;
        e.t   = t;
        e.lat = eh ? (2 + ep) : 3;
        sb.push_back(e);
        wait_done();
    endtask

    task automatic do_reset_and_flush();
        int n;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("flush_busy_cycles", 64'(n), 64'd64);
        chk("ready_after_flush", 64'(bus.req_ready), 64'd1);
    endtask

    task automatic clear_stats();
        stats_clr = 1'b1;
        @(negedge clk);
        stats_clr = 1'b0;
    endtask

    function automatic logic [31:0] addr_of(input int tag, input int set);
        return (32'(tag) << 10) | (32'(set) << 4);
    endfunction

    initial begin
        int t;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_store = 1'b0;
        @(negedge clk);

        // reset state and flush length
        do_reset_and_flush();
        chk("reset_access", 64'(access_count), 64'd0);
        chk("reset_hist", hit_hist, 64'd0);
        chk("reset_resp_pos", 64'(bus.resp_pos), 64'd0);

        // first miss, then hit at position 0
        access(32'h0000_0400, 1'b0, 1'b0, 16, 1'b0);
        access(32'h0000_0400, 1'b0, 1'b1, 0, 1'b0);
        chk("hist0_after_hit", 64'(hit_hist[0 +: CNT_W]), 64'd1);
        chk("access_2", 64'(access_count), 64'd2);
        chk("miss_1", 64'(miss_count), 64'd1);

        // fill set 0, deep hit, saturation
        clear_stats();
        chk("clr_access", 64'(access_count), 64'd0);
        chk("clr_hist", hit_hist, 64'd0);
        for (int i = 0; i < 15; i++) access(addr_of(2 + i, 0), 1'b0, 1'b0, 16, 1'b0);
        chk("access_15", 64'(access_count), 64'd15);
        access(addr_of(17, 0), 1'b0, 1'b0, 16, 1'b0);
        chk("access_saturated", 64'(access_count), 64'd15);
        chk("miss_saturated", 64'(miss_count), 64'd15);
        access(addr_of(2, 0), 1'b0, 1'b1, 15, 1'b0);
        chk("hist15", 64'(hit_hist[15*CNT_W +: CNT_W]), 64'd1);
        access(addr_of(2, 0), 1'b0, 1'b1, 0, 1'b0);
        chk("hist0_fill", 64'(hit_hist[0 +: CNT_W]), 64'd1);

        // dirty eviction of a store-miss line
        clear_stats();
        access(addr_of(100, 1), 1'b1, 1'b0, 16, 1'b0);
        for (int i = 0; i < 16; i++) access(addr_of(101 + i, 1), 1'b0, 1'b0, 16, i == 15);
        chk("dirty_evict_1", 64'(dirty_evict_count), 64'd1);
        access(addr_of(117, 1), 1'b0, 1'b0, 16, 1'b0);
        chk("dirty_evict_still_1", 64'(dirty_evict_count), 64'd1);

        // store hit at p=1 dirties the moved line; a later load keeps it dirty
        access(addr_of(200, 2), 1'b0, 1'b0, 16, 1'b0);
        access(addr_of(201, 2), 1'b0, 1'b0, 16, 1'b0);
        access(addr_of(200, 2), 1'b1, 1'b1, 1, 1'b0);
        access(addr_of(200, 2), 1'b0, 1'b1, 0, 1'b0);
        for (int i = 0; i < 16; i++) access(addr_of(202 + i, 2), 1'b0, 1'b0, 16, i == 15);
        chk("dirty_evict_2", 64'(dirty_evict_count), 64'd2);

        // stats_clr coinciding with the increment
        hs(addr_of(500, 4), 1'b0, t);
        stats_clr = 1'b1;
        sb.push_back('{hit: 1'b0, pos: 5'd16, ev: 1'b0, t: t, lat: 3});
        @(negedge clk);
        stats_clr = 1'b0;
        wait_done();
        chk("clr_wins_access", 64'(access_count), 64'd0);
        chk("clr_wins_miss", 64'(miss_count), 64'd0);

        // reset during the shift of a position-10 hit
        for (int i = 0; i < 11; i++) access(addr_of(400 + i, 3), 1'b0, 1'b0, 16, 1'b0);
        hs(addr_of(400, 3), 1'b0, t);
        repeat (3) @(negedge clk);
        do_reset_and_flush();
        chk("rst_access", 64'(access_count), 64'd0);
        chk("rst_miss", 64'(miss_count), 64'd0);
        chk("rst_devict", 64'(dirty_evict_count), 64'd0);
        chk("rst_hist", hit_hist, 64'd0);
        chk("rst_resp_hit", 64'(bus.resp_hit), 64'd0);
        access(addr_of(400, 3), 1'b0, 1'b0, 16, 1'b0);
        access(32'h0000_0400, 1'b0, 1'b0, 16, 1'b0);

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation time limit expected completion");
        $fatal(1, "watchdog");
    end
endmodule
